// File: rtl/spw_tx_pkg.sv
// -----------------------------------------------------------------------------
// spw_tx_pkg
// Shared definitions for the SpaceWire transmitter character sequencer:
//   - TX state codes (start is all-zero, every other state is one-hot)
//   - char_type codes reported to the serialiser / counters
//   - default character lengths in bits
//   - small helper used for elaboration-time range checks
// -----------------------------------------------------------------------------
package spw_tx_pkg;

    localparam int STATE_W = 7;

    localparam logic [STATE_W-1:0] tx_spw_start       = 7'b0000000;
    localparam logic [STATE_W-1:0] tx_spw_null        = 7'b0000001;
    localparam logic [STATE_W-1:0] tx_spw_fct         = 7'b0000010;
    localparam logic [STATE_W-1:0] tx_spw_null_c      = 7'b0000100;
    localparam logic [STATE_W-1:0] tx_spw_fct_c       = 7'b0001000;
    localparam logic [STATE_W-1:0] tx_spw_data_c      = 7'b0010000;
    localparam logic [STATE_W-1:0] tx_spw_data_c_0    = 7'b0100000;
    localparam logic [STATE_W-1:0] tx_spw_time_code_c = 7'b1000000;

    typedef enum logic [2:0] {
        CHAR_IDLE = 3'd0,
        CHAR_NULL = 3'd1,
        CHAR_FCT  = 3'd2,
        CHAR_DATA = 3'd3,
        CHAR_EOP  = 3'd4,
        CHAR_TIME = 3'd5
    } char_type_e;

    localparam int DEF_NULL_LEN = 8;
    localparam int DEF_FCT_LEN  = 4;
    localparam int DEF_DATA_LEN = 10;
    localparam int DEF_TIME_LEN = 14;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spw_tx_char_len_dec.sv
// -----------------------------------------------------------------------------
// spw_tx_char_len_dec
// Combinational decode of the TX state (plus the control-character flags) into
// the character length in bits, its char_type code and an illegal-code flag.
// Also used by the RX-side checker, so it carries no state.
// Ports:
//   state     in   STATE_W   TX state code
//   send_null in   1         start state: begin a NULL instead of idling
//   ctrl      in   1         data_c carries EOP/EEP instead of an N-char
//   ctrl_0    in   1         data_c_0 carries EOP/EEP instead of an N-char
//   len       out  LEN_W     character length in bits (0 = nothing to send)
//   ctype     out  3         char_type code
//   illegal   out  1         state is not a known code
// -----------------------------------------------------------------------------
module spw_tx_char_len_dec
    import spw_tx_pkg::*;
#(
    parameter int LEN_W    = 4,
    parameter int NULL_LEN = DEF_NULL_LEN,
    parameter int FCT_LEN  = DEF_FCT_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int TIME_LEN = DEF_TIME_LEN
) (
    input  logic [STATE_W-1:0] state,
    input  logic               send_null,
    input  logic               ctrl,
    input  logic               ctrl_0,
    output logic [LEN_W-1:0]   len,
    output logic [2:0]         ctype,
    output logic               illegal
);

    always_comb begin
        len     = '0;
        ctype   = CHAR_IDLE;
        illegal = 1'b0;
        case (state)
            tx_spw_start: begin
                // Without send_null the start state is a legal idle: length 0.
                if (send_null) begin
                    len   = LEN_W'(NULL_LEN);
                    ctype = CHAR_NULL;
                end
            end
            tx_spw_null, tx_spw_null_c: begin
                len   = LEN_W'(NULL_LEN);
                ctype = CHAR_NULL;
            end
            tx_spw_fct, tx_spw_fct_c: begin
                len   = LEN_W'(FCT_LEN);
                ctype = CHAR_FCT;
            end
            tx_spw_data_c: begin
                len   = ctrl ? LEN_W'(FCT_LEN) : LEN_W'(DATA_LEN);
                ctype = ctrl ? CHAR_EOP : CHAR_DATA;
            end
            tx_spw_data_c_0: begin
                len   = ctrl_0 ? LEN_W'(FCT_LEN) : LEN_W'(DATA_LEN);
                ctype = ctrl_0 ? CHAR_EOP : CHAR_DATA;
            end
            tx_spw_time_code_c: begin
                len   = LEN_W'(TIME_LEN);
                ctype = CHAR_TIME;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/spw_tx_char_sequencer.sv
// -----------------------------------------------------------------------------
// spw_tx_char_sequencer
// Bit-slot sequencer between the TX state machine and the DS serialiser.
// Tracks the bit position inside the current character (one-hot and binary),
// flags the last bit, pulses on completion, counts characters and reports
// state changes made mid-character or illegal state codes (sticky).
// Ports:
//   pclk_tx       in   1       clock, rising edge
//   enable_tx     in   1       synchronous active-low reset
//   send_null_tx  in   1       start state sends NULLs
//   tick_en       in   1       bit-rate strobe
//   state_tx      in   7       TX state code
//   tx_data_in    in   1       data_c is EOP/EEP
//   tx_data_in_0  in   1       data_c_0 is EOP/EEP
//   slot_onehot   out  SLOT_W  one-hot bit slot
//   bit_idx       out  IDX_W   binary bit index
//   char_last     out  1       current bit is the last of the character
//   char_done     out  1       one-cycle pulse after the last bit
//   char_type     out  3       latched char_type code
//   char_count    out  CNT_W   completed characters (wrapping)
//   seq_err       out  1       sticky sequencing error
// -----------------------------------------------------------------------------
module spw_tx_char_sequencer
    import spw_tx_pkg::*;
#(
    parameter int SLOT_W   = 14,
    parameter int NULL_LEN = DEF_NULL_LEN,
    parameter int FCT_LEN  = DEF_FCT_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int TIME_LEN = DEF_TIME_LEN,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1,
    localparam int LEN_W   = $clog2(SLOT_W + 1)
) (
    input  logic               pclk_tx,
    input  logic               enable_tx,
    input  logic               send_null_tx,
    input  logic               tick_en,
    input  logic [STATE_W-1:0] state_tx,
    input  logic               tx_data_in,
    input  logic               tx_data_in_0,
    output logic [SLOT_W-1:0]  slot_onehot,
    output logic [IDX_W-1:0]   bit_idx,
    output logic               char_last,
    output logic               char_done,
    output logic [2:0]         char_type,
    output logic [CNT_W-1:0]   char_count,
    output logic               seq_err
);

    localparam int MAX_LEN = max4(NULL_LEN, FCT_LEN, DATA_LEN, TIME_LEN);

    generate
        if (MAX_LEN > SLOT_W) begin : g_len_check
            $error("spw_tx_char_sequencer: a character length exceeds SLOT_W");
        end
    endgenerate

    logic [LEN_W-1:0]   dec_len;
    logic [2:0]         dec_type;
    logic               dec_illegal;

    logic [LEN_W-1:0]   len_q,       len_d;
    logic [STATE_W-1:0] state_q,     state_d;
    logic [2:0]         type_q,      type_d;
    logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;
    logic [SLOT_W-1:0]  slot_q,      slot_d;
    logic               char_last_q, char_last_d;
    logic               char_done_q, char_done_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               seq_err_q,   seq_err_d;

    logic               at_start;
    logic [LEN_W-1:0]   eff_len;
    logic               last_bit;

    spw_tx_char_len_dec #(
        .LEN_W    (LEN_W),
        .NULL_LEN (NULL_LEN),
        .FCT_LEN  (FCT_LEN),
        .DATA_LEN (DATA_LEN),
        .TIME_LEN (TIME_LEN)
    ) u_len_dec (
        .state     (state_tx),
        .send_null (send_null_tx),
        .ctrl      (tx_data_in),
        .ctrl_0    (tx_data_in_0),
        .len       (dec_len),
        .ctype     (dec_type),
        .illegal   (dec_illegal)
    );

    // Slot 0 is both the first bit of a new character and the decision point
    // for its length, so the freshly decoded length governs that tick. This
    // gives back-to-back characters with no gap slot.
    assign at_start = (bit_idx_q == '0);
    assign eff_len  = at_start ? dec_len : len_q;
    assign last_bit = (eff_len != '0) && (LEN_W'(bit_idx_q) == eff_len - LEN_W'(1));

    always_comb begin
        len_d       = len_q;
        state_d     = state_q;
        type_d      = type_q;
        bit_idx_d   = bit_idx_q;
        slot_d      = slot_q;
        char_done_d = 1'b0;
        count_d     = count_q;
        seq_err_d   = seq_err_q;

        if (tick_en) begin
            if (at_start) begin
                len_d   = dec_len;
                type_d  = dec_type;
                state_d = state_tx;
                if (dec_illegal) begin
                    seq_err_d = 1'b1;
                end
            end
            // A zero length (idle start or illegal code) parks the slot at 0.
            if (eff_len != '0) begin
                if (last_bit) begin
                    bit_idx_d   = '0;
                    slot_d      = SLOT_W'(1);
                    char_done_d = 1'b1;
                    count_d     = count_q + CNT_W'(1);
                end else begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    slot_d    = slot_q << 1;
                end
            end
        end

        // The running character keeps its latched length; the change is only
        // reported here and honoured at the next start.
        if (!at_start && (state_tx != state_q)) begin
            seq_err_d = 1'b1;
        end

        char_last_d = (len_d != '0) && (LEN_W'(bit_idx_d) == len_d - LEN_W'(1));
    end

    always_ff @(posedge pclk_tx) begin
        if (!enable_tx) begin
            len_q       <= '0;
            state_q     <= tx_spw_start;
            type_q      <= CHAR_IDLE;
            bit_idx_q   <= '0;
            slot_q      <= SLOT_W'(1);
            char_last_q <= 1'b0;
            char_done_q <= 1'b0;
            count_q     <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            len_q       <= len_d;
            state_q     <= state_d;
            type_q      <= type_d;
            bit_idx_q   <= bit_idx_d;
            slot_q      <= slot_d;
            char_last_q <= char_last_d;
            char_done_q <= char_done_d;
            count_q     <= count_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign slot_onehot = slot_q;
    assign bit_idx     = bit_idx_q;
    assign char_last   = char_last_q;
    assign char_done   = char_done_q;
    assign char_type   = type_q;
    assign char_count  = count_q;
    assign seq_err     = seq_err_q;

endmodule
